line_scan_encoder: RTL and testbench
====================================

LINE_SCAN_ENCODER -- requirements
Module: line_scan_encoder

Interface
REQ-001 Parameter DEB_CYCLES, default 4, number of consecutive stable samples required to accept a press or a release (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 L  input  7  raw, asynchronous line requests L[0]..L[6] from panel switches.
REQ-005 ack  input  1  consumer acknowledge for the current code; sampled only in state VALID.
REQ-006 V  output  1  code valid.
REQ-007 Ch  output  3  channel code; 3'b000 means "no line", L[i] maps to i+1.
REQ-008 MULTI  output  1  more than one line was active in the accepted sample.

Function
REQ-009 L shall pass through a 2-flop synchronizer before any use; sL denotes the synchronized value.
REQ-010 The FSM shall have states IDLE, DEBOUNCE, VALID, RELEASE, with an 8-bit counter cnt.
REQ-011 IDLE: if sL != 0, latch cand = sL, clear cnt, go to DEBOUNCE; otherwise stay.
REQ-012 DEBOUNCE: if sL != cand, clear cnt and go to IDLE; else increment cnt, and on the edge where cnt reaches DEB_CYCLES-1, go to VALID.
REQ-013 On entry to VALID, Ch shall register the lowest-index set bit of cand, plus 1 (priority to L[0]), MULTI shall register (popcount(cand) > 1), and V shall register 1.
REQ-014 VALID: V, Ch and MULTI shall hold stable until ack=1 is sampled; on that edge go to RELEASE, and V, Ch and MULTI shall read 0 in the following cycle.
REQ-015 RELEASE: each cycle with sL == 0 increments cnt, and any sL != 0 clears cnt; when cnt reaches DEB_CYCLES-1 with sL == 0, go to IDLE.
REQ-016 ack asserted outside VALID shall be ignored; an ack held high across states shall never produce more than one code per press.
REQ-017 With the input stable from edge 0, V shall rise after edge DEB_CYCLES+3 (2 sync, 1 capture, DEB_CYCLES count).
REQ-018 A change of sL during VALID shall not alter Ch or MULTI.
REQ-019 All outputs shall be driven directly from flops (no combinational path from L or ack to outputs).

Reset
REQ-020 rst=1 shall immediately force state IDLE, with cnt, cand, synchronizer flops, V, Ch and MULTI all 0, including mid-DEBOUNCE or mid-VALID.
REQ-021 After rst deasserts, a line already held high shall be treated as a new press, with the full REQ-017 latency.

Structure
REQ-022 A shared package shall hold the state enum (IDLE, DEBOUNCE, VALID, RELEASE), CH_NONE = 3'b000, and the line count constant NUM_LINES = 7.
REQ-023 The synchronizer shall be a sub-module, line_sync, 7 bits wide with 2 stages and async active-high reset; the priority encoder stays inline.

Verification
REQ-024 DEB_CYCLES=4, L=7'b0000100 held from edge 0 -> V=1, Ch=3'b011, MULTI=0 after edge 7; ack pulse -> V=0 next cycle.
REQ-025 L=7'b1000010 held -> Ch=3'b010, MULTI=1; L[6] alone -> Ch=3'b111.
REQ-026 L[3] glitch of 3 cycles, then 0 -> FSM returns to IDLE, and V never asserts.
REQ-027 ack held high permanently while L[0] is pressed and then released -> exactly one V pulse with Ch=3'b001; a second press after 4 clean low samples -> a second pulse.
REQ-028 rst asserted in VALID -> V=0, Ch=0, MULTI=0 asynchronously; with L still held after rst release -> V reasserts after 7 edges.
REQ-029 L[5] bounce (1,0,1) during RELEASE -> IDLE only after 4 consecutive low samples, and no spurious V.

Source files
------------

// File: rtl/line_scan_encoder_pkg.sv
// Shared types and constants for the line scan encoder: FSM states,
// the "no line" channel code and the number of panel lines.
package line_scan_encoder_pkg;

    localparam int NUM_LINES = 7;

    localparam logic [2:0] CH_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        VALID,
        RELEASE
    } state_t;

endpackage

// File: rtl/line_sync.sv
// Two-stage synchronizer for the raw panel lines. Both stages clear on the
// asynchronous reset, so a line that is still held is seen again as a new press.
module line_sync
    import line_scan_encoder_pkg::*;
#(
    parameter int WIDTH = NUM_LINES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/line_scan_encoder.sv
// Debounced priority encoder for seven panel lines. A press must hold the same
// pattern for DEB_CYCLES samples; the code is held until acknowledged.
module line_scan_encoder
    import line_scan_encoder_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LINES-1:0] L,
    input  logic                 ack,
    output logic                 V,
    output logic [2:0]           Ch,
    output logic                 MULTI
);

    localparam logic [7:0]           CNT_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [NUM_LINES-1:0] LINE_ONE = NUM_LINES'(1);

    logic [NUM_LINES-1:0] sL;
    logic [NUM_LINES-1:0] cand;
    logic [7:0]           cnt;
    logic [2:0]           enc_ch;
    logic                 enc_multi;
    state_t               state;

    line_sync #(
        .WIDTH (NUM_LINES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (L),
        .q   (sL)
    );

    // Walking from the top line down lets the lowest set line win.
    always_comb begin
        enc_ch = CH_NONE;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                enc_ch = 3'(i + 1);
            end
        end
    end

    assign enc_multi = (cand & (cand - LINE_ONE)) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
            V     <= 1'b0;
            Ch    <= CH_NONE;
            MULTI <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sL != '0) begin
                        cand  <= sL;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (sL != cand) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= VALID;
                        V     <= 1'b1;
                        Ch    <= enc_ch;
                        MULTI <= enc_multi;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (ack) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        V     <= 1'b0;
                        Ch    <= CH_NONE;
                        MULTI <= 1'b0;
                    end
                end
                RELEASE: begin
                    // Any active line restarts the release count, so bounces
                    // cannot sneak a second code out of one press.
                    if (sL != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_scan_encoder.sv
// Directed bench for line_scan_encoder with DEB_CYCLES=4: latency, encoding,
// glitch rejection, held ack, async reset and release bounce.
module tb_line_scan_encoder;

    logic       clk;
    logic       rst;
    logic [6:0] L;
    logic       ack;
    logic       V;
    logic [2:0] Ch;
    logic       MULTI;

    int checkCount = 0;
    int errorCount = 0;
    int pulseCount = 0;
    int pulseMark  = 0;
    logic prevV = 1'b0;

    line_scan_encoder #(
        .DEB_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .L     (L),
        .ack   (ack),
        .V     (V),
        .Ch    (Ch),
        .MULTI (MULTI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges of V seen mid-cycle, one per emitted code.
    always @(negedge clk) begin
        if (V && !prevV) pulseCount++;
        prevV = V;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] lines, input logic a);
        L   = lines;
        ack = a;
    endtask

    task automatic checkOutput(input string tag, input logic expV,
                               input logic [2:0] expCh, input logic expMulti);
        checkCount++;
        assert (V === expV) else begin
            errorCount++;
            $error("[TB] FAIL %s V observed=%b expected=%b", tag, V, expV);
        end
        checkCount++;
        assert (Ch === expCh) else begin
            errorCount++;
            $error("[TB] FAIL %s Ch observed=%b expected=%b", tag, Ch, expCh);
        end
        checkCount++;
        assert (MULTI === expMulti) else begin
            errorCount++;
            $error("[TB] FAIL %s MULTI observed=%b expected=%b", tag, MULTI, expMulti);
        end
    endtask

    task automatic checkPulses(input string tag, input int expected);
        checkCount++;
        assert (pulseCount === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s pulses observed=%0d expected=%0d", tag, pulseCount, expected);
        end
    endtask

    task automatic ackPulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(7'b0000000, 1'b0);
        tick(2);
        checkOutput("reset_state", 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        tick(2);
        checkOutput("idle_after_reset", 1'b0, 3'b000, 1'b0);

        $display("[TB] single line L[2], latency and hold");
        applyStimulus(7'b0000100, 1'b0);
        tick(6);
        checkOutput("l2_before_edge7", 1'b0, 3'b000, 1'b0);
        tick(1);
        checkOutput("l2_at_edge7", 1'b1, 3'b011, 1'b0);
        applyStimulus(7'b0000001, 1'b0);
        tick(4);
        checkOutput("l2_hold_line_change", 1'b1, 3'b011, 1'b0);
        ackPulse();
        checkOutput("l2_after_ack", 1'b0, 3'b000, 1'b0);
        applyStimulus(7'b0000000, 1'b0);
        tick(8);

        $display("[TB] multi line and top line");
        applyStimulus(7'b1000010, 1'b0);
        tick(7);
        checkOutput("multi_l1_l6", 1'b1, 3'b010, 1'b1);
        ackPulse();
        applyStimulus(7'b0000000, 1'b0);
        tick(8);
        applyStimulus(7'b1000000, 1'b0);
        tick(7);
        checkOutput("top_l6", 1'b1, 3'b111, 1'b0);
        ackPulse();
        applyStimulus(7'b0000000, 1'b0);
        tick(8);

        $display("[TB] three-cycle glitch on L[3]");
        pulseMark = pulseCount;
        applyStimulus(7'b0001000, 1'b0);
        tick(3);
        applyStimulus(7'b0000000, 1'b0);
        tick(12);
        checkPulses("glitch_no_v", pulseMark);
        applyStimulus(7'b0001000, 1'b0);
        tick(6);
        checkOutput("after_glitch_edge6", 1'b0, 3'b000, 1'b0);
        tick(1);
        checkOutput("after_glitch_edge7", 1'b1, 3'b100, 1'b0);
        ackPulse();
        applyStimulus(7'b0000000, 1'b0);
        tick(8);

        $display("[TB] ack held high across two presses");
        pulseMark = pulseCount;
        applyStimulus(7'b0000001, 1'b1);
        tick(7);
        checkOutput("held_ack_first", 1'b1, 3'b001, 1'b0);
        tick(1);
        checkOutput("held_ack_first_drop", 1'b0, 3'b000, 1'b0);
        tick(10);
        applyStimulus(7'b0000000, 1'b1);
        tick(8);
        checkPulses("held_ack_one_pulse", pulseMark + 1);
        applyStimulus(7'b0000001, 1'b1);
        tick(7);
        checkOutput("held_ack_second", 1'b1, 3'b001, 1'b0);
        tick(1);
        checkOutput("held_ack_second_drop", 1'b0, 3'b000, 1'b0);
        checkPulses("held_ack_two_pulses", pulseMark + 2);
        applyStimulus(7'b0000000, 1'b0);
        tick(8);

        $display("[TB] reset during VALID");
        applyStimulus(7'b0000010, 1'b0);
        tick(7);
        checkOutput("pre_reset_valid", 1'b1, 3'b010, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_valid", 1'b0, 3'b000, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(6);
        checkOutput("post_reset_edge6", 1'b0, 3'b000, 1'b0);
        tick(1);
        checkOutput("post_reset_edge7", 1'b1, 3'b010, 1'b0);
        ackPulse();
        applyStimulus(7'b0000000, 1'b0);
        tick(8);

        $display("[TB] L[5] bounce during RELEASE");
        applyStimulus(7'b0100000, 1'b0);
        tick(7);
        checkOutput("bounce_valid", 1'b1, 3'b110, 1'b0);
        ackPulse();
        pulseMark = pulseCount;
        applyStimulus(7'b0000000, 1'b0);
        tick(3);
        applyStimulus(7'b0100000, 1'b0);
        tick(1);
        applyStimulus(7'b0000000, 1'b0);
        tick(2);
        applyStimulus(7'b0100000, 1'b0);
        tick(1);
        applyStimulus(7'b0000000, 1'b0);
        tick(3);
        // Only three clean lows reach the FSM before this press shows up.
        applyStimulus(7'b0000100, 1'b0);
        tick(12);
        checkPulses("bounce_no_spurious", pulseMark);
        checkOutput("bounce_still_release", 1'b0, 3'b000, 1'b0);
        applyStimulus(7'b0000000, 1'b0);
        tick(8);
        applyStimulus(7'b0000100, 1'b0);
        tick(6);
        checkOutput("after_bounce_edge6", 1'b0, 3'b000, 1'b0);
        tick(1);
        checkOutput("after_bounce_edge7", 1'b1, 3'b011, 1'b0);
        ackPulse();
        checkOutput("after_bounce_ack", 1'b0, 3'b000, 1'b0);
        applyStimulus(7'b0000000, 1'b0);
        tick(8);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
